jk_count_sequencer: RTL and testbench
=====================================

Name: jk_count_sequencer

Overview:
- Upstream control stage for a bank of WIDTH jk flip-flop cells.
- Accepts commands through a valid/ready handshake and drives one J/K pair per bit: load a value, count up N steps, count down N steps, or do nothing.
- Reads the bank's current state back on q_in and computes the J/K excitation combinationally from it.
- Handles sequencing, step counting, terminal-count and completion signalling.

Parameters:
- WIDTH, 4, number of jk cells in the driven bank (counter width).
- CNT_W, 8, width of the step-count field and the internal remaining-step counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 NOP, 01 LOAD, 10 UP, 11 DOWN.
- cmd_data  input  WIDTH  load value (LOAD only).
- cmd_steps  input  CNT_W  number of count steps (UP/DOWN only).
- q_in  input  WIDTH  current q of the jk bank.
- j_out  output  WIDTH  J inputs to the bank, bit i drives cell i.
- k_out  output  WIDTH  K inputs to the bank.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on command completion.
- tc  output  1  one-cycle pulse the cycle after any count edge that wrapped.

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
  - While reset is high: state = IDLE, remaining = 0, latched command cleared.
  - Outputs during reset: j_out = k_out = 0, done = 0, tc = 0, busy = 0, cmd_ready = 1.
  - The same reset clears the jk bank, so q_in = 0 after reset.
- Handshake:
  - Accept occurs on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = 1 only in IDLE.
  - cmd_op, cmd_data and cmd_steps are latched at accept; later input changes are ignored.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: j_out = k_out = 0 (bank holds). On accept:
    - NOP -> DONE.
    - LOAD -> LOAD.
    - UP/DOWN with steps = 0 -> DONE.
    - UP/DOWN with steps > 0 -> RUN, remaining = steps.
  - LOAD: one cycle with j_out = data, k_out = ~data; the bank takes data on the next edge. -> DONE.
  - RUN (UP): t[i] = AND of q_in[i-1:0], with t[0] = 1.
  - RUN (DOWN): t[i] = AND of ~q_in[i-1:0], with t[0] = 1.
  - RUN outputs: j_out = k_out = t (toggle mode). Each edge in RUN advances the bank by exactly one, modulo 2^WIDTH.
  - RUN counter: remaining decrements every edge; when remaining == 1 at the edge -> DONE.
  - DONE: j_out = k_out = 0, done = 1 for exactly this cycle, cmd_ready = 0. -> IDLE.
- Latency, with accept at edge E0:
  - LOAD: bank updates at E1; done high in the cycle after E1; IDLE after E2.
  - UP/DOWN N: bank steps at edges E1..EN; done high in the cycle after EN.
  - NOP or N = 0: done high in the cycle after E0; q_in unchanged.
- J/K excitation is combinational from the registered state and q_in; the bank q is not shadowed internally.
- tc is a registered pulse, set in the cycle after a RUN edge where:
  - UP and q_in = all ones beforehand (wrap to 0), or
  - DOWN and q_in = all zeros beforehand (wrap to all ones).
  - tc can coincide with done.
- Reset mid-operation: immediate return to IDLE with outputs zeroed; no done pulse for the aborted command.
- Back-to-back commands: minimum one IDLE cycle between done and the next accept.

Test Plan:
- Reset, then LOAD 0xA -> j_out = 1010, k_out = 0101 for 1 cycle; q_in = 0xA after E1; done pulses once; busy drops after DONE.
- LOAD 0xD, then UP steps = 5 -> q sequence E, F, 0, 1, 2; tc pulses exactly once, the cycle after the F -> 0 edge; one done; final q = 0x2.
- LOAD 0x2, then DOWN steps = 4 -> q sequence 1, 0, F, E; one tc, after the 0 -> F edge; final q = 0xE.
- UP steps = 0 from q = 0x7 -> done in the cycle after accept; j_out = k_out = 0 throughout; q stays 0x7; tc = 0.
- cmd_valid held high with a new command during UP steps = 3 -> cmd_ready = 0 until IDLE; the second command is accepted only after done; changing cmd_data/cmd_steps mid-RUN has no effect (exactly 3 steps).
- reset asserted after 3 edges of UP steps = 10 -> busy = 0 and j_out = k_out = 0 immediately (async); q = 0; no done or tc; next LOAD 0x5 works normally.

Source files
------------

// File: rtl/jk_count_sequencer.sv
// Control stage for a bank of JK flip-flop cells: accepts LOAD/UP/DOWN/NOP
// commands over valid/ready and drives per-bit J/K excitation from the bank's q.
module jk_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b11;
    localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] toggle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            remaining_q <= '0;
            tc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            tc_q        <= tc_d;
        end
    end

    // Ripple-carry toggle mask: bit i flips when all lower bits are at the carry (UP) or borrow (DOWN) value.
    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if (op_q == OP_DOWN) begin
                toggle[i] = toggle[i-1] & ~q_in[i-1];
            end else begin
                toggle[i] = toggle[i-1] & q_in[i-1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        tc_d        = 1'b0;
        j_out       = '0;
        k_out       = '0;
        done        = 1'b0;
        cmd_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    data_d      = cmd_data;
                    remaining_d = '0;
                    if (cmd_op == OP_NOP) begin
                        state_d = ST_DONE;
                    end else if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (cmd_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_RUN;
                        remaining_d = cmd_steps;
                    end
                end
            end
            ST_LOAD: begin
                j_out   = data_q;
                k_out   = ~data_q;
                state_d = ST_DONE;
            end
            ST_RUN: begin
                j_out       = toggle;
                k_out       = toggle;
                remaining_d = remaining_q - STEP_ONE;
                // The wrap is judged on the pre-edge q, so tc lands alongside the wrapped value.
                tc_d        = (op_q == OP_DOWN) ? ~|q_in : &q_in;
                if (remaining_q == STEP_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign tc   = tc_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Bench for jk_count_sequencer: a JK bank model closes the loop and an arithmetic
// reference predicts q, done, tc, busy and J/K for every cycle of each command.
module tb_jk_count_sequencer;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_steps;
    logic [W-1:0]  bank_q;
    logic [W-1:0]  j_out;
    logic [W-1:0]  k_out;
    logic          busy;
    logic          done;
    logic          tc;

    int pass_count  = 0;
    int check_count = 0;
    int fail_count  = 0;

    always #5 clk = ~clk;

    jk_count_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .q_in      (bank_q),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .tc        (tc)
    );

    // JK bank: Q+ = J&~Q | ~K&Q per cell, cleared by the shared reset.
    always @(posedge clk or posedge reset) begin
        if (reset) bank_q <= '0;
        else       bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit is_count(input logic [1:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

    // Bank value expected k cycles after accept, from plain modular arithmetic.
    function automatic logic [W-1:0] expect_q(input logic [1:0] op, input logic [W-1:0] data,
                                              input int steps, input logic [W-1:0] q0, input int k);
        int n;
        n = (k < steps) ? k : steps;
        case (op)
            OP_LOAD: return (k >= 1) ? data : q0;
            OP_UP:   return W'((int'(q0) + n) % 16);
            OP_DOWN: return W'(((int'(q0) - n) % 16 + 16) % 16);
            default: return q0;
        endcase
    endfunction

    function automatic int expect_done_cycle(input logic [1:0] op, input int steps);
        if (op == OP_NOP || (is_count(op) && steps == 0)) return 0;
        if (op == OP_LOAD) return 1;
        return steps;
    endfunction

    // Present a command at a negedge, wait (bounded) for acceptance, return at the first sample after accept.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data,
                                 input logic [CW-1:0] steps, output logic [W-1:0] q0);
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = steps;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        checkOutput("accept_ready", cmd_ready, 1);
        q0 = bank_q;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Walk every cycle of one command, returning at the IDLE sample after done.
    task automatic trackCommand(input logic [1:0] op, input logic [W-1:0] data,
                                input int steps, input logic [W-1:0] q0);
        int done_cycle;
        logic [W-1:0] eq, prev, ej, ek;
        logic etc;
        done_cycle = expect_done_cycle(op, steps);
        for (int k = 0; k <= done_cycle + 1; k++) begin
            eq  = expect_q(op, data, steps, q0, k);
            etc = 1'b0;
            if (is_count(op) && k >= 1 && k <= steps) begin
                prev = expect_q(op, data, steps, q0, k - 1);
                etc  = (op == OP_UP) ? (prev == 4'hF) : (prev == 4'h0);
            end
            ej = '0;
            ek = '0;
            if (k < done_cycle) begin
                if (op == OP_LOAD) begin
                    ej = data;
                    ek = ~data;
                end else begin
                    ej = eq ^ expect_q(op, data, steps, q0, k + 1);
                    ek = ej;
                end
            end
            checkOutput("q", bank_q, eq);
            checkOutput("done", done, (k == done_cycle));
            checkOutput("busy", busy, (k <= done_cycle));
            checkOutput("cmd_ready", cmd_ready, (k > done_cycle));
            checkOutput("tc", tc, etc);
            checkOutput("j_out", j_out, ej);
            checkOutput("k_out", k_out, ek);
            if (k < done_cycle) begin
                cmd_data  = W'($urandom);
                cmd_steps = CW'($urandom);
            end
            if (k <= done_cycle) @(negedge clk);
        end
    endtask

    task automatic runCommand(input logic [1:0] op, input logic [W-1:0] data, input logic [CW-1:0] steps);
        logic [W-1:0] q0;
        applyStimulus(op, data, steps, q0);
        cmd_valid = 1'b0;
        trackCommand(op, data, int'(steps), q0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] q0;
        logic [1:0]   rop;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        cmd_steps = '0;
        #12;
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_jk", {j_out, k_out}, 0);
        checkOutput("rst_done_tc", {done, tc}, 0);
        checkOutput("rst_q", bank_q, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed load/up/down");
        runCommand(OP_LOAD, 4'hA, 0);
        runCommand(OP_LOAD, 4'hD, 0);
        runCommand(OP_UP,   4'h0, 5);
        runCommand(OP_LOAD, 4'h2, 0);
        runCommand(OP_DOWN, 4'h0, 4);
        runCommand(OP_LOAD, 4'h7, 0);
        runCommand(OP_UP,   4'h0, 0);
        runCommand(OP_NOP,  4'h3, 9);

        $display("[TB] valid held during run");
        applyStimulus(OP_UP, 4'h0, 3, q0);
        cmd_op = OP_LOAD;
        trackCommand(OP_UP, 4'h0, 3, q0);
        cmd_data = 4'h9;
        applyStimulus(OP_LOAD, 4'h9, 0, q0);
        cmd_valid = 1'b0;
        trackCommand(OP_LOAD, 4'h9, 0, q0);

        $display("[TB] reset mid-run");
        applyStimulus(OP_UP, 4'h0, 10, q0);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_abort_q", bank_q, expect_q(OP_UP, 4'h0, 10, q0, 3));
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_jk", {j_out, k_out}, 0);
        checkOutput("abort_ready", cmd_ready, 1);
        checkOutput("abort_q", bank_q, 0);
        @(negedge clk);
        checkOutput("abort_done_tc", {done, tc}, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_abort_done_tc", {done, tc}, 0);
        runCommand(OP_LOAD, 4'h5, 0);

        $display("[TB] random commands");
        for (int n = 0; n < 25; n++) begin
            rop = 2'($urandom_range(0, 3));
            runCommand(rop, W'($urandom), CW'($urandom_range(0, 20)));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
